// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester arithmetic-unit sequencer:
// op codes, FSM state encoding and the default operand width.
package alu_share_pkg;

  localparam int W_DEFAULT = 6;

  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b11;
  localparam logic [1:0] OP_BAD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_mul.sv
// Iterative unsigned shift-add multiplier: one bit of b per cycle, LSB first.
// done_o is high during the final step; prod_o then carries the exact product.
module alu_share_mul
  import alu_share_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);

  localparam int CW = $clog2(W + 1);

  logic           busy_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] a_sh_q;
  logic [W-1:0]   b_sh_q;
  logic [2*W-1:0] acc_d;
  logic           last;

  always_comb begin
    acc_d  = acc_q + (b_sh_q[0] ? a_sh_q : '0);
    last   = busy_q && (cnt_q == CW'(1));
    done_o = last;
    prod_o = acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(W);
    end else if (busy_q) begin
      cnt_q <= cnt_q - CW'(1);
      if (last) busy_q <= 1'b0;
    end
  end

  // Operand shifters and accumulator carry no reset; busy_q qualifies them.
  always_ff @(posedge clk) begin
    if (start_i) begin
      acc_q  <= '0;
      a_sh_q <= {{W{1'b0}}, a_i};
      b_sh_q <= b_i;
    end else if (busy_q) begin
      acc_q  <= acc_d;
      a_sh_q <= a_sh_q << 1;
      b_sh_q <= b_sh_q >> 1;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one add/sub/mul unit between two requesters,
// returning a tagged 2W-bit result over a valid/ready port.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [1:0]     req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  input  logic [1:0]     req1_op,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_data,
  output logic           res_tag,
  output logic           res_err
);

  state_e         state_q, state_d;
  logic           rr_q, rr_d;
  logic [W-1:0]   a_q, b_q;
  logic [1:0]     op_q;
  logic [2*W-1:0] res_data_q, res_data_d;
  logic           res_tag_q, res_tag_d;
  logic           res_err_q, res_err_d;

  logic           gnt0, gnt1, fire0, fire1, accept;
  logic [W-1:0]   sel_a, sel_b;
  logic [1:0]     sel_op;
  logic           mul_start, mul_done;
  logic [2*W-1:0] mul_prod;

  // a-b as a (W+1)-bit two's complement value, sign-extended to 2W.
  function automatic logic [2*W-1:0] sub_ext(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return {{(W-1){d[W]}}, d};
  endfunction

  function automatic logic [2*W-1:0] add_ext(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {{(W-1){1'b0}}, s};
  endfunction

  alu_share_mul #(.W(W)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start_i(mul_start),
    .a_i    (sel_a),
    .b_i    (sel_b),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  always_comb begin
    gnt0   = req0_valid && (!req1_valid || !rr_q);
    gnt1   = req1_valid && (!req0_valid || rr_q);
    fire0  = req0_valid && req0_ready;
    fire1  = req1_valid && req1_ready;
    accept = fire0 || fire1;
    sel_a  = fire1 ? req1_a  : req0_a;
    sel_b  = fire1 ? req1_b  : req0_b;
    sel_op = fire1 ? req1_op : req0_op;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (sel_op == OP_BAD) ? DONE : EXEC;
      EXEC: if (op_q != OP_MUL || mul_done) state_d = DONE;
      DONE: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && !rst && gnt0;
    req1_ready = (state_q == IDLE) && !rst && gnt1;
    res_valid  = (state_q == DONE);
    mul_start  = accept && (sel_op == OP_MUL);
    res_data   = res_data_q;
    res_tag    = res_tag_q;
    res_err    = res_err_q;
  end

  // Result register is written on accept (tag/err) and on leaving EXEC (data).
  always_comb begin
    rr_d       = rr_q;
    res_data_d = res_data_q;
    res_tag_d  = res_tag_q;
    res_err_d  = res_err_q;
    if (accept) begin
      rr_d       = fire0;
      res_tag_d  = fire1;
      res_err_d  = (sel_op == OP_BAD);
      res_data_d = '0;
    end else if (state_q == EXEC) begin
      case (op_q)
        OP_SUB:  res_data_d = sub_ext(a_q, b_q);
        OP_ADD:  res_data_d = add_ext(a_q, b_q);
        OP_MUL:  if (mul_done) res_data_d = mul_prod;
        default: res_data_d = res_data_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q       <= 1'b0;
      res_data_q <= '0;
      res_tag_q  <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      res_data_q <= res_data_d;
      res_tag_q  <= res_tag_d;
      res_err_q  <= res_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= sel_a;
      b_q  <= sel_b;
      op_q <= sel_op;
    end
  end

endmodule
